// File: rtl/branch_target_predictor_if.sv
// rtl/branch_target_predictor_if.sv - fetch lookup and EX resolution bundle for the branch target predictor
//
// Purpose: groups the fetch-side lookup signals, the EX-side resolution
// signals and the performance counter outputs of branch_target_predictor.
// Modports:
//   master - fetch/EX pipeline side: drives pc_if and ex_*, receives predictions
//   slave  - predictor side: receives pc_if and ex_*, drives predictions,
//            mispredict/fix_npc and the counters
interface branch_target_predictor_if;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic        ex_valid;
  logic        ex_is_br;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] ex_pred_npc;
  logic        mispredict;
  logic [31:0] fix_npc;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  modport master (
    output pc_if, ex_valid, ex_is_br, ex_pc, ex_taken, ex_target, ex_pred_npc,
    input  pred_taken, pred_npc, mispredict, fix_npc, br_cnt, miss_cnt
  );

  modport slave (
    input  pc_if, ex_valid, ex_is_br, ex_pc, ex_taken, ex_target, ex_pred_npc,
    output pred_taken, pred_npc, mispredict, fix_npc, br_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with 2-bit BHT counters for fetch next-PC prediction
//
// Purpose: looks up the fetch PC combinationally and predicts the next fetch
// PC; takes resolved conditional branches from EX to raise mispredict/fix_npc
// and to update the table one cycle later.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset (clears every valid bit, counters to 01)
//   bus   - branch_target_predictor_if.slave (pc_if/pred_*, ex_*/mispredict/fix_npc,
//           br_cnt/miss_cnt)
// Optional feature macro: BHT_PERF_CNT_EN enables the br_cnt/miss_cnt
// counters; without it both outputs are tied to zero.
module branch_target_predictor #(
  parameter int IDX_BITS = 6
) (
  input logic                     clk,
  input logic                     rst_n,
  branch_target_predictor_if.slave bus
);

  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam int ENTRIES  = 1 << IDX_BITS;

  // Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST; bit 1 is the prediction.
  logic [ENTRIES-1:0]  valid_q;
  logic [1:0]          cnt_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic                if_hit;
  logic                pred_taken;

  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                ex_hit;
  logic                upd;
  logic [31:0]         ex_seq_npc;
  logic [31:0]         actual_npc;
  logic                mispredict;

  // Fetch-side lookup; reads the pre-update table even when EX writes the same index.
  assign if_idx     = bus.pc_if[IDX_BITS+1:2];
  assign if_tag     = bus.pc_if[31:IDX_BITS+2];
  assign if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken = if_hit && cnt_q[if_idx][1];

  assign bus.pred_taken = pred_taken;
  assign bus.pred_npc   = pred_taken ? target_q[if_idx] : bus.pc_if + 32'd4;

  // EX-side resolution; rst_n gates upd so nothing is written or flushed in reset.
  assign ex_idx     = bus.ex_pc[IDX_BITS+1:2];
  assign ex_tag     = bus.ex_pc[31:IDX_BITS+2];
  assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd        = bus.ex_valid && bus.ex_is_br && rst_n;
  assign ex_seq_npc = bus.ex_pc + 32'd4;
  assign actual_npc = bus.ex_taken ? bus.ex_target : ex_seq_npc;
  assign mispredict = upd && (bus.ex_pred_npc != actual_npc);

  assign bus.mispredict = mispredict;
  assign bus.fix_npc    = upd ? actual_npc : ex_seq_npc;

  // Valid bits and counters carry reset state; a single reset cycle wipes them all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b01;
      end
    end else if (upd) begin
      if (ex_hit) begin
        if (bus.ex_taken) begin
          if (cnt_q[ex_idx] != 2'b11) cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'd1;
        end else begin
          if (cnt_q[ex_idx] != 2'b00) cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'd1;
        end
      end else if (bus.ex_taken) begin
        // Taken miss replaces whatever occupied the slot, starting weakly taken.
        valid_q[ex_idx] <= 1'b1;
        cnt_q[ex_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target need no reset: they are only meaningful once valid is set.
  // On a taken hit the tag rewrite is a no-op, so both cases share one write.
  always_ff @(posedge clk) begin
    if (upd && bus.ex_taken) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= bus.ex_target;
    end
  end

`ifdef BHT_PERF_CNT_EN
  logic [31:0] br_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q   <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (upd)        br_cnt_q   <= br_cnt_q + 32'd1;
      if (mispredict) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.br_cnt   = br_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
`else
  assign bus.br_cnt   = 32'd0;
  assign bus.miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - scoreboard bench for branch_target_predictor
module tb_branch_target_predictor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_target_predictor_if bus();

  branch_target_predictor #(.IDX_BITS(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  localparam int K_TAKEN = 0, K_NPC = 1, K_MIS = 2, K_FIX = 3, K_BR = 4, K_MISS = 5;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  // One cycle of stimulus plus the outputs it must produce before the next edge.
  typedef struct packed {
    logic [31:0] pc;
    logic        v;
    logic        br;
    logic [31:0] xpc;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] xpred;
    logic        e_tk;
    logic [31:0] e_npc;
    logic        e_mis;
    logic [31:0] e_fix;
  } step_t;

  function automatic logic [31:0] observed(int kind);
    case (kind)
      K_TAKEN: return {31'd0, bus.pred_taken};
      K_NPC:   return bus.pred_npc;
      K_MIS:   return {31'd0, bus.mispredict};
      K_FIX:   return bus.fix_npc;
      K_BR:    return bus.br_cnt;
      default: return bus.miss_cnt;
    endcase
  endfunction

  task automatic push_exp(string name, int kind, logic [31:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic drive_ex(logic v, logic br, logic [31:0] xpc, logic tk,
                          logic [31:0] tgt, logic [31:0] xpred);
    bus.ex_valid    = v;
    bus.ex_is_br    = br;
    bus.ex_pc       = xpc;
    bus.ex_taken    = tk;
    bus.ex_target   = tgt;
    bus.ex_pred_npc = xpred;
  endtask

  task automatic apply(string tag, step_t s);
    bus.pc_if = s.pc;
    drive_ex(s.v, s.br, s.xpc, s.tk, s.tgt, s.xpred);
    push_exp({tag, ".pred_taken"}, K_TAKEN, {31'd0, s.e_tk});
    push_exp({tag, ".pred_npc"},   K_NPC,   s.e_npc);
    push_exp({tag, ".mispredict"}, K_MIS,   {31'd0, s.e_mis});
    push_exp({tag, ".fix_npc"},    K_FIX,   s.e_fix);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    bus.pc_if = 32'h0;
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.pc_if = 32'h1C;
    push_exp("reset.pred_taken", K_TAKEN, 32'd0);
    push_exp("reset.pred_npc",   K_NPC,   32'h20);
    push_exp("reset.mispredict", K_MIS,   32'd0);
    push_exp("reset.fix_npc",    K_FIX,   32'h4);
    push_exp("reset.br_cnt",     K_BR,    32'd0);
    push_exp("reset.miss_cnt",   K_MISS,  32'd0);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (observed(e.kind) !== e.val) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, observed(e.kind), e.val);
      end
    end
    tick();
  endtask

  task automatic test_alloc();
    step_t st[$];
    exp_t  e;
    st.push_back('{32'h1C, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14, 32'h20, 1'b0, 32'h20, 1'b1, 32'h14});
    st.push_back('{32'h1C, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,  1'b1, 32'h14, 1'b0, 32'h4});
    foreach (st[i]) begin
      apply($sformatf("alloc%0d", i), st[i]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (observed(e.kind) !== e.val) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, observed(e.kind), e.val);
        end
      end
      tick();
    end
  endtask

  // Walks the 0x1C counter 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 01.
  task automatic test_hysteresis();
    step_t st[$];
    exp_t  e;
    st.push_back('{32'h1C, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14, 32'h14, 1'b1, 32'h14, 1'b0, 32'h14});
    st.push_back('{32'h1C, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14, 32'h14, 1'b1, 32'h14, 1'b0, 32'h14});
    st.push_back('{32'h1C, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h14, 32'h14, 1'b1, 32'h14, 1'b1, 32'h20});
    st.push_back('{32'h1C, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h14, 32'h14, 1'b1, 32'h14, 1'b1, 32'h20});
    st.push_back('{32'h1C, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h14, 32'h20, 1'b0, 32'h20, 1'b0, 32'h20});
    st.push_back('{32'h1C, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14, 32'h20, 1'b0, 32'h20, 1'b1, 32'h14});
    st.push_back('{32'h1C, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,  1'b0, 32'h20, 1'b0, 32'h4});
    foreach (st[i]) begin
      apply($sformatf("hyst%0d", i), st[i]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (observed(e.kind) !== e.val) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, observed(e.kind), e.val);
        end
      end
      tick();
    end
  endtask

  // 0x11C shares index 7 with 0x1C but carries a different tag.
  task automatic test_alias();
    step_t st[$];
    exp_t  e;
    st.push_back('{32'h11C, 1'b1, 1'b1, 32'h11C, 1'b1, 32'h200, 32'h120, 1'b0, 32'h120, 1'b1, 32'h200});
    st.push_back('{32'h11C, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   1'b1, 32'h200, 1'b0, 32'h4});
    st.push_back('{32'h1C,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   1'b0, 32'h20,  1'b0, 32'h4});
    foreach (st[i]) begin
      apply($sformatf("alias%0d", i), st[i]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (observed(e.kind) !== e.val) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, observed(e.kind), e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_same_cycle();
    step_t st[$];
    exp_t  e;
    st.push_back('{32'h24, 1'b1, 1'b1, 32'h24, 1'b1, 32'h10, 32'h28, 1'b0, 32'h28, 1'b1, 32'h10});
    st.push_back('{32'h24, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,  1'b1, 32'h10, 1'b0, 32'h4});
    foreach (st[i]) begin
      apply($sformatf("same%0d", i), st[i]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (observed(e.kind) !== e.val) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, observed(e.kind), e.val);
        end
      end
      tick();
    end
  endtask

  // Non-branch, invalid and not-taken-miss resolutions must leave the table alone.
  task automatic test_no_write();
    step_t st[$];
    exp_t  e;
    st.push_back('{32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 32'h0, 1'b0, 32'h44, 1'b0, 32'h44});
    st.push_back('{32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 32'h0, 1'b0, 32'h44, 1'b0, 32'h44});
    st.push_back('{32'h40, 1'b1, 1'b1, 32'h50, 1'b0, 32'h80, 32'h0, 1'b0, 32'h44, 1'b1, 32'h54});
    st.push_back('{32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0, 1'b0, 32'h44, 1'b0, 32'h4});
    st.push_back('{32'h50, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0, 1'b0, 32'h54, 1'b0, 32'h4});
    foreach (st[i]) begin
      apply($sformatf("nowrite%0d", i), st[i]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (observed(e.kind) !== e.val) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, observed(e.kind), e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    step_t st[$];
    exp_t  e;
    st.push_back('{32'hFFFFFFFC, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0,   1'b0, 32'h0});
    st.push_back('{32'hFFFFFFFC, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b1, 32'h100, 32'h0, 1'b0, 32'h0,   1'b1, 32'h100});
    st.push_back('{32'hFFFFFFFC, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0, 1'b1, 32'h100, 1'b0, 32'h4});
    foreach (st[i]) begin
      apply($sformatf("wrap%0d", i), st[i]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (observed(e.kind) !== e.val) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, observed(e.kind), e.val);
        end
      end
      tick();
    end
  endtask

  // One reset cycle with a live taken branch: no flush, no write, all entries gone.
  task automatic test_reset_mid();
    logic [31:0] pcs[$];
    exp_t        e;
    rst_n = 1'b0;
    bus.pc_if = 32'h1C;
    drive_ex(1'b1, 1'b1, 32'h60, 1'b1, 32'h300, 32'h0);
    push_exp("rstmid.mispredict", K_MIS, 32'd0);
    push_exp("rstmid.fix_npc",    K_FIX, 32'h64);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (observed(e.kind) !== e.val) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, observed(e.kind), e.val);
      end
    end
    tick();
    rst_n = 1'b1;
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    pcs = '{32'h1C, 32'h11C, 32'h24, 32'h60, 32'hFFFFFFFC};
    foreach (pcs[i]) begin
      bus.pc_if = pcs[i];
      push_exp($sformatf("rstmid.lookup%0d.pred_taken", i), K_TAKEN, 32'd0);
      push_exp($sformatf("rstmid.lookup%0d.pred_npc", i),   K_NPC,   pcs[i] + 32'd4);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (observed(e.kind) !== e.val) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, observed(e.kind), e.val);
        end
      end
      tick();
    end
  endtask

  // 9 taken then 1 not-taken at 0x1C, ex_pred_npc taken from the live prediction.
  task automatic test_perf_cnt();
    exp_t e;
    int   exp_br   = 0;
    int   exp_miss = 0;
    rst_n = 1'b0;
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.pc_if = 32'h1C;
      #1;
      drive_ex(1'b1, 1'b1, 32'h1C, (i < 9), 32'h14, bus.pred_npc);
      exp_br++;
      // First taken is a cold miss; the final not-taken hits a taken-biased counter.
      if (i == 0 || i == 9) exp_miss++;
      tick();
    end
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
`ifdef BHT_PERF_CNT_EN
    push_exp("perf.br_cnt",   K_BR,   exp_br);
    push_exp("perf.miss_cnt", K_MISS, exp_miss);
`else
    push_exp("perf.br_cnt",   K_BR,   32'd0);
    push_exp("perf.miss_cnt", K_MISS, 32'd0);
`endif
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (observed(e.kind) !== e.val) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, observed(e.kind), e.val);
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alloc();
    test_hysteresis();
    test_alias();
    test_same_cycle();
    test_no_write();
    test_wrap();
    test_reset_mid();
    test_perf_cnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
Fetch-stage next-PC predictor directly upstream of the instruction cache. It holds a direct-mapped BTB with a 2-bit saturating BHT counter per entry. It looks up the current fetch PC combinationally and drives the predicted next PC into the PC register, which addresses the icache. The EX stage feeds resolved conditional branches back for table update and for mispredict/flush generation.

Parameters:
IDX_BITS, 6, log2 of entry count (64 entries); index = pc[IDX_BITS+1:2]
TAG_BITS, 30-IDX_BITS (derived, localparam), tag = pc[31:IDX_BITS+2]

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
pc_if  in  32  PC currently being fetched (same value sent as icache addr)
pred_taken  out  1  prediction for pc_if: BTB hit and counter predicts taken
pred_npc  out  32  predicted next fetch PC
ex_valid  in  1  EX stage holds a valid instruction this cycle
ex_is_br  in  1  EX instruction is a conditional branch
ex_pc  in  32  PC of EX instruction
ex_taken  in  1  resolved branch outcome
ex_target  in  32  resolved branch target
ex_pred_npc  in  32  pred_npc carried down the pipe with this instruction
mispredict  out  1  flush request
fix_npc  out  32  correct next PC on mispredict
br_cnt  out  32  branches resolved (optional feature)
miss_cnt  out  32  mispredicts (optional feature)

Behaviour:
- Reset is synchronous and active-low; polarity and synchronicity are fixed. Single clock, clk.
- Storage per entry: valid, tag, target[31:0], cnt[1:0]. Encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Reset (rst_n=0 at posedge): all valid=0 and all cnt=01. Tag/target contents are don't-care. Updates are suppressed while rst_n=0. Reset mid-operation discards every entry within that single cycle.
- Lookup is combinational from pc_if: hit = valid[idx] && tag[idx]==pc_if tag.
  - pred_taken = hit && cnt[idx][1]
  - pred_npc = pred_taken ? target[idx] : pc_if+4 (32-bit wrap; 0xFFFFFFFC -> 0x00000000)
  - After reset: pred_taken=0 and pred_npc=pc_if+4.
- Resolution is combinational. upd = ex_valid && ex_is_br && rst_n.
  - actual_npc = ex_taken ? ex_target : ex_pc+4
  - mispredict = upd && (ex_pred_npc != actual_npc)
  - fix_npc = actual_npc whenever upd; otherwise ex_pc+4
  - Non-branch or invalid EX: mispredict=0, no table write.
- Update is written at the posedge when upd=1, on the entry indexed by ex_pc:
  - Hit, taken: cnt saturating +1 (11 stays 11); target <= ex_target.
  - Hit, not taken: cnt saturating -1 (00 stays 00); target unchanged.
  - Miss, taken: allocate (replace): valid=1, tag, target=ex_target, cnt=10.
  - Miss, not taken: no write.
- Simultaneous lookup and update of the same index: lookup returns the pre-update contents. The new state is visible from the next cycle.
- Only conditional branches are handled; JAL/JALR redirection is outside this block.
- Latency: prediction 0 cycles (combinational); table update 1 cycle.

Optional Feature:
BHT_PERF_CNT_EN
- Defined: br_cnt and miss_cnt are 32-bit registers, reset to 0.
  - br_cnt increments on every upd.
  - miss_cnt increments on every mispredict.
  - Both wrap at 2^32.
- Undefined: both ports remain present and are tied to 0; no counter registers.

Test Plan:
- Reset, pc_if=0x1C -> pred_taken=0, pred_npc=0x20.
- ex_pc=0x1C taken, ex_target=0x14, ex_pred_npc=0x20 -> mispredict=1, fix_npc=0x14. Next cycle pc_if=0x1C -> pred_taken=1, pred_npc=0x14 (cnt=10).
- Hysteresis: 2 more taken updates at 0x1C (cnt=11). Then not-taken -> still predicts 0x14 (cnt=10). Second not-taken -> pred_npc=0x20 (cnt=01). Not-taken with ex_pred_npc=0x20 -> mispredict=0.
- Aliasing: after 0x1C is allocated, taken update at ex_pc=0x11C, target 0x200 -> lookup 0x11C gives 0x200; lookup 0x1C misses, pred_npc=0x20.
- Same-cycle: pc_if=ex_pc=0x24 with a first taken update (target 0x10) -> that cycle pred_npc=0x28; next cycle 0x10. Reset asserted mid-sequence -> next cycle all lookups miss.
- With BHT_PERF_CNT_EN: from reset, feed 9 taken then 1 not-taken at 0x1C (target 0x14), ex_pred_npc looped from pred_npc -> br_cnt=10, miss_cnt=2. Without the macro both read 0.
